cfg_vpd_loader: RTL and testbench

Boot-time loader for the card-specific read-only configuration fields: serial number, subsystem ID and subsystem vendor ID. After reset it fetches a 16-byte record from the card's VPD flash through a byte-read handshake and validates it. It then drives the validated values, or fixed defaults on any failure, onto the inputs of cfg_func0 and cfg_func1. It sits directly upstream of the config functions, in place of constant tie-offs for these fields.

---
 rtl/cfg_vpd_loader.sv | 148 ++++++++++++++
 tb/tb_cfg_vpd_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_vpd_loader.sv
// rtl/cfg_vpd_loader.sv - boot-time VPD record loader for card-specific RO config fields
module cfg_vpd_loader #(
  parameter logic [63:0] DEFAULT_SERIAL           = 64'hDEAD_DEAD_DEAD_DEAD,
  parameter logic [15:0] DEFAULT_SUBSYS_ID        = 16'h0666,
  parameter logic [15:0] DEFAULT_SUBSYS_VENDOR_ID = 16'h1014,
  parameter logic [23:0] BASE_ADDR                = 24'h000000,
  parameter logic [15:0] MAGIC                    = 16'h4F43,
  parameter int          TIMEOUT_CYCLES           = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        reload,
  output logic        rd_req,
  output logic [23:0] rd_addr,
  input  logic        rd_ack,
  input  logic [7:0]  rd_data,
  output logic [63:0] f0_ro_dsn_serial_number,
  output logic [15:0] f0_ro_csh_subsystem_id,
  output logic [15:0] f0_ro_csh_subsystem_vendor_id,
  output logic [15:0] f1_ro_csh_subsystem_id,
  output logic [15:0] f1_ro_csh_subsystem_vendor_id,
  output logic        vpd_done,
  output logic [1:0]  vpd_status
);

  localparam int              CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_BUSY    = 2'b00;
  localparam logic [1:0] ST_LOADED  = 2'b01;
  localparam logic [1:0] ST_BAD     = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {REQ, GAP, CHECK, DONE} state_t;

  state_t             state, state_next;
  logic               started;
  logic [3:0]         index;
  logic [13:0][7:0]   shadow;
  logic [7:0]         sum;
  logic [CW-1:0]      tmo_cnt;
  logic               take;
  logic               tmo_hit;
  logic               record_ok;

  // The reset cycle sits in REQ, but the request is held off until the first edge after release.
  assign rd_req    = started && (state == REQ);
  assign rd_addr   = rd_req ? (BASE_ADDR + {20'd0, index}) : 24'd0;
  assign take      = rd_req && rd_ack;
  assign tmo_hit   = rd_req && !rd_ack && (tmo_cnt == TMO_LAST);
  assign record_ok = ({shadow[0], shadow[1]} == MAGIC) && (sum == 8'h00);

  assign f1_ro_csh_subsystem_id        = f0_ro_csh_subsystem_id;
  assign f1_ro_csh_subsystem_vendor_id = f0_ro_csh_subsystem_vendor_id;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= REQ;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      REQ: begin
        if (take) begin
          state_next = GAP;
        end else if (tmo_hit) begin
          state_next = DONE;
        end
      end
      GAP:     state_next = (index == 4'd15) ? CHECK : REQ;
      CHECK:   state_next = DONE;
      DONE:    state_next = reload ? REQ : DONE;
      default: state_next = REQ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      started                       <= 1'b0;
      index                         <= 4'd0;
      shadow                        <= '0;
      sum                           <= 8'h00;
      tmo_cnt                       <= '0;
      f0_ro_dsn_serial_number       <= DEFAULT_SERIAL;
      f0_ro_csh_subsystem_id        <= DEFAULT_SUBSYS_ID;
      f0_ro_csh_subsystem_vendor_id <= DEFAULT_SUBSYS_VENDOR_ID;
      vpd_done                      <= 1'b0;
      vpd_status                    <= ST_BUSY;
    end else begin
      started <= 1'b1;
      case (state)
        REQ: begin
          if (take) begin
            // Reserved and checksum bytes only feed the running sum.
            if (index < 4'd14) begin
              shadow[index] <= rd_data;
            end
            sum <= sum + rd_data;
          end else if (tmo_hit) begin
            f0_ro_dsn_serial_number       <= DEFAULT_SERIAL;
            f0_ro_csh_subsystem_id        <= DEFAULT_SUBSYS_ID;
            f0_ro_csh_subsystem_vendor_id <= DEFAULT_SUBSYS_VENDOR_ID;
            vpd_status                    <= ST_TIMEOUT;
            vpd_done                      <= 1'b1;
          end else if (rd_req) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        GAP: begin
          index   <= index + 4'd1;
          tmo_cnt <= '0;
        end
        CHECK: begin
          if (record_ok) begin
            f0_ro_dsn_serial_number       <= {shadow[2], shadow[3], shadow[4], shadow[5],
                                              shadow[6], shadow[7], shadow[8], shadow[9]};
            f0_ro_csh_subsystem_id        <= {shadow[10], shadow[11]};
            f0_ro_csh_subsystem_vendor_id <= {shadow[12], shadow[13]};
            vpd_status                    <= ST_LOADED;
          end else begin
            f0_ro_dsn_serial_number       <= DEFAULT_SERIAL;
            f0_ro_csh_subsystem_id        <= DEFAULT_SUBSYS_ID;
            f0_ro_csh_subsystem_vendor_id <= DEFAULT_SUBSYS_VENDOR_ID;
            vpd_status                    <= ST_BAD;
          end
          vpd_done <= 1'b1;
        end
        DONE: begin
          // Field outputs keep their last values until the next load completes.
          if (reload) begin
            vpd_done   <= 1'b0;
            vpd_status <= ST_BUSY;
            index      <= 4'd0;
            shadow     <= '0;
            sum        <= 8'h00;
            tmo_cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_vpd_loader.sv
// tb/tb_cfg_vpd_loader.sv - directed self-checking bench for cfg_vpd_loader
module tb_cfg_vpd_loader;

  localparam logic [23:0] BASE      = 24'hFFFFF8;
  localparam logic [15:0] MAGIC_V   = 16'h4F43;
  localparam logic [63:0] DEF_SER   = 64'hDEAD_DEAD_DEAD_DEAD;
  localparam logic [15:0] DEF_ID    = 16'h0666;
  localparam logic [15:0] DEF_VID   = 16'h1014;

  typedef logic [15:0][7:0] rec_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        reload = 1'b0;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic        rd_ack = 1'b0;
  logic [7:0]  rd_data = 8'h00;
  logic [63:0] f0_serial;
  logic [15:0] f0_id, f0_vid, f1_id, f1_vid;
  logic        vpd_done;
  logic [1:0]  vpd_status;

  int n_checks = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int hold_bad = 0;
  bit hold_active = 1'b0;
  logic [63:0] hold_serial = '0;

  cfg_vpd_loader #(
    .DEFAULT_SERIAL(DEF_SER),
    .DEFAULT_SUBSYS_ID(DEF_ID),
    .DEFAULT_SUBSYS_VENDOR_ID(DEF_VID),
    .BASE_ADDR(BASE),
    .MAGIC(MAGIC_V),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .reload(reload),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_ack(rd_ack),
    .rd_data(rd_data),
    .f0_ro_dsn_serial_number(f0_serial),
    .f0_ro_csh_subsystem_id(f0_id),
    .f0_ro_csh_subsystem_vendor_id(f0_vid),
    .f1_ro_csh_subsystem_id(f1_id),
    .f1_ro_csh_subsystem_vendor_id(f1_vid),
    .vpd_done(vpd_done),
    .vpd_status(vpd_status)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  always @(negedge clock) begin
    if (hold_active && (f0_serial !== hold_serial)) hold_bad <= hold_bad + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1ms, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_fields(input string tag, input logic [63:0] s, input logic [15:0] id,
                               input logic [15:0] vid);
    expect_eq({tag, "_serial"}, f0_serial, s);
    expect_eq({tag, "_f0_id"}, {48'd0, f0_id}, {48'd0, id});
    expect_eq({tag, "_f0_vid"}, {48'd0, f0_vid}, {48'd0, vid});
    expect_eq({tag, "_f1_id"}, {48'd0, f1_id}, {48'd0, id});
    expect_eq({tag, "_f1_vid"}, {48'd0, f1_vid}, {48'd0, vid});
  endtask

  function automatic rec_t make_rec(input logic [63:0] s, input logic [15:0] id,
                                    input logic [15:0] vid, input logic [7:0] delta);
    rec_t r;
    logic [7:0] acc;
    r[0] = MAGIC_V[15:8];
    r[1] = MAGIC_V[7:0];
    for (int k = 0; k < 8; k++) r[2+k] = s[63-8*k -: 8];
    r[10] = id[15:8];
    r[11] = id[7:0];
    r[12] = vid[15:8];
    r[13] = vid[7:0];
    r[14] = 8'hA5;
    acc = 8'h00;
    for (int k = 0; k < 15; k++) acc = acc + r[k];
    r[15] = (8'h00 - acc) + delta;
    return r;
  endfunction

  task automatic pulse_reload();
    @(negedge clock);
    reload = 1'b1;
    @(posedge clock);
    #1;
    reload = 1'b0;
  endtask

  task automatic serve(input rec_t rec, input bit rand_lat, input bit spurious, input int n_bytes,
                       input int reload_at, output int first_edge);
    int lat;
    bit seen;
    first_edge = -1;
    for (int i = 0; i < n_bytes; i++) begin
      seen = 1'b0;
      for (int n = 0; n < 64 && !seen; n++) begin
        @(negedge clock);
        seen = rd_req;
      end
      if (!seen) begin
        expect_eq($sformatf("req_wait_b%0d", i), 64'd0, 64'd1);
        return;
      end
      if (i == 0) first_edge = edge_cnt;
      expect_eq($sformatf("addr_b%0d", i), {40'd0, rd_addr}, {40'd0, BASE + 24'(i)});
      lat = rand_lat ? int'($urandom_range(0, 9)) : 0;
      repeat (lat) @(negedge clock);
      rd_ack = 1'b1;
      rd_data = rec[i];
      if (i == reload_at) reload = 1'b1;
      @(posedge clock);
      #1;
      rd_ack = 1'b0;
      reload = 1'b0;
      rd_data = 8'h00;
      if (spurious) begin
        rd_ack = 1'b1;
        rd_data = 8'h5A;
        @(posedge clock);
        #1;
        rd_ack = 1'b0;
      end
    end
  endtask

  task automatic wait_done(output int done_edge);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clock);
      seen = vpd_done;
    end
    if (!seen) expect_eq("done_wait", 64'd0, 64'd1);
    done_edge = edge_cnt;
  endtask

  rec_t rec_good, rec_bad, rec_one;
  int   fe, de, req_cycles;
  bit   seen;

  initial begin
    rec_good = make_rec(64'h0123_4567_89AB_CDEF, 16'h0777, 16'h1014, 8'h00);
    rec_bad  = make_rec(64'h0123_4567_89AB_CDEF, 16'h0777, 16'h1014, 8'h01);
    rec_one  = make_rec(64'h1111_1111_1111_1111, 16'h0888, 16'h2222, 8'h00);

    // Reset state
    repeat (3) @(negedge clock);
    expect_eq("rst_req", {63'd0, rd_req}, 64'd0);
    expect_eq("rst_addr", {40'd0, rd_addr}, 64'd0);
    expect_eq("rst_done", {63'd0, vpd_done}, 64'd0);
    expect_eq("rst_status", {62'd0, vpd_status}, 64'd0);
    expect_fields("rst", DEF_SER, DEF_ID, DEF_VID);

    // Valid record, ack in the first request cycle: done 33 edges after rd_req rises
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    serve(rec_good, 1'b0, 1'b0, 16, -1, fe);
    wait_done(de);
    expect_eq("good_latency", 64'(de - fe), 64'd33);
    expect_eq("good_status", {62'd0, vpd_status}, 64'd1);
    expect_eq("good_req_low", {63'd0, rd_req}, 64'd0);
    expect_fields("good", 64'h0123_4567_89AB_CDEF, 16'h0777, 16'h1014);

    // Checksum off by one
    pulse_reload();
    expect_eq("bad_busy_done", {63'd0, vpd_done}, 64'd0);
    serve(rec_bad, 1'b0, 1'b0, 16, -1, fe);
    wait_done(de);
    expect_eq("bad_status", {62'd0, vpd_status}, 64'd2);
    expect_fields("bad", DEF_SER, DEF_ID, DEF_VID);

    // No ack at all: 16 request cycles then timeout
    pulse_reload();
    req_cycles = 0;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clock);
      if (rd_req) req_cycles++;
      seen = vpd_done;
    end
    expect_eq("tmo_seen_done", {63'd0, seen}, 64'd1);
    expect_eq("tmo_req_cycles", 64'(req_cycles), 64'd16);
    expect_eq("tmo_req_low", {63'd0, rd_req}, 64'd0);
    expect_eq("tmo_status", {62'd0, vpd_status}, 64'd3);
    expect_fields("tmo", DEF_SER, DEF_ID, DEF_VID);

    // Random latency, spurious acks in GAP, an ignored reload mid-load
    pulse_reload();
    serve(rec_good, 1'b1, 1'b1, 16, 5, fe);
    wait_done(de);
    expect_eq("rand_status", {62'd0, vpd_status}, 64'd1);
    expect_fields("rand", 64'h0123_4567_89AB_CDEF, 16'h0777, 16'h1014);
    repeat (3) begin
      @(negedge clock);
      rd_ack = 1'b1;
      rd_data = 8'hFF;
      @(negedge clock);
      rd_ack = 1'b0;
    end
    expect_eq("done_spur_req", {63'd0, rd_req}, 64'd0);
    expect_eq("done_spur_done", {63'd0, vpd_done}, 64'd1);
    expect_eq("done_spur_status", {62'd0, vpd_status}, 64'd1);

    // Reload with a new serial: old values held until the new load completes
    hold_serial = 64'h0123_4567_89AB_CDEF;
    hold_bad = 0;
    pulse_reload();
    hold_active = 1'b1;
    @(negedge clock);
    expect_eq("reload_done", {63'd0, vpd_done}, 64'd0);
    expect_eq("reload_status", {62'd0, vpd_status}, 64'd0);
    serve(rec_one, 1'b0, 1'b0, 16, -1, fe);
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clock);
      seen = vpd_done;
      if (!seen && f0_serial !== hold_serial) hold_bad++;
    end
    hold_active = 1'b0;
    expect_eq("reload_seen_done", {63'd0, seen}, 64'd1);
    expect_eq("reload_hold_bad", 64'(hold_bad), 64'd0);
    expect_eq("reload_new_status", {62'd0, vpd_status}, 64'd1);
    expect_fields("reload_new", 64'h1111_1111_1111_1111, 16'h0888, 16'h2222);

    // Asynchronous reset while byte 7 is being requested
    pulse_reload();
    serve(rec_good, 1'b0, 1'b0, 7, -1, fe);
    seen = 1'b0;
    for (int n = 0; n < 64 && !seen; n++) begin
      @(negedge clock);
      seen = rd_req;
    end
    expect_eq("b7_req_seen", {63'd0, seen}, 64'd1);
    expect_eq("b7_addr", {40'd0, rd_addr}, {40'd0, BASE + 24'd7});
    reset_n = 1'b0;
    #1;
    expect_eq("arst_req", {63'd0, rd_req}, 64'd0);
    expect_eq("arst_addr", {40'd0, rd_addr}, 64'd0);
    expect_eq("arst_done", {63'd0, vpd_done}, 64'd0);
    expect_eq("arst_status", {62'd0, vpd_status}, 64'd0);
    expect_fields("arst", DEF_SER, DEF_ID, DEF_VID);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    serve(rec_good, 1'b0, 1'b0, 16, -1, fe);
    wait_done(de);
    expect_eq("post_rst_latency", 64'(de - fe), 64'd33);
    expect_eq("post_rst_status", {62'd0, vpd_status}, 64'd1);
    expect_fields("post_rst", 64'h0123_4567_89AB_CDEF, 16'h0777, 16'h1014);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
